dmem_resp: RTL and testbench
============================

DMEM_RESP -- requirements
Module: dmem_resp

Interface
REQ-001 The block SHALL have parameter DEPTH, default 1024: number of 32-bit words in the array; power of two, at least 4.
REQ-002 The block SHALL have parameter BASE_ADDR, default 32'h0000_0000: byte address of word 0; 4-byte aligned.
REQ-003 The block SHALL have port clk_sys, input, width 1: single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_sys, input, width 1: reset, asynchronous and active-high.
REQ-005 The block SHALL have port i_mem_wen, input, width 1: write request from the memory-access stage.
REQ-006 The block SHALL have port i_mem_ren, input, width 1: read request from the memory-access stage.
REQ-007 The block SHALL have port i_mem_addr, input, width 32: byte address of the request.
REQ-008 The block SHALL have port i_mem_wdata, input, width 32: write data.
REQ-009 The block SHALL have port o_mem_rdata, output, width 32: registered read data.
REQ-010 The block SHALL have port o_rdata_vld, output, width 1: one-cycle pulse marking valid o_mem_rdata.
REQ-011 The block SHALL have port i_err_clr, input, width 1: clears the sticky error.
REQ-012 The block SHALL have port o_err, output, width 1: sticky access-error flag.
REQ-013 The block SHALL have port o_err_addr, output, width 32: address of the first faulting access since the last clear.
REQ-014 The block SHALL have port o_rd_cnt, output, width 32: count of accepted legal reads.
REQ-015 The block SHALL have port o_wr_cnt, output, width 32: count of accepted legal writes.

Function
REQ-016 An access SHALL be legal only when it is aligned (i_mem_addr[1:0]==0) and i_mem_addr-BASE_ADDR is at or above 0 and below DEPTH*4; the word index is (i_mem_addr-BASE_ADDR)>>2.
REQ-017 A legal write SHALL update the addressed word at the clock edge where i_mem_wen=1.
REQ-018 An illegal write SHALL leave the array unchanged.
REQ-019 Read latency SHALL be exactly 1 cycle: when i_mem_ren=1 at edge N, o_mem_rdata carries the data and o_rdata_vld=1 during the cycle after edge N.
REQ-020 o_rdata_vld SHALL be 0 in every cycle not preceded by a read request.
REQ-021 An illegal read SHALL return o_mem_rdata=0 and still pulse o_rdata_vld.
REQ-022 o_mem_rdata SHALL hold its last value while no read is in progress.
REQ-023 Back-to-back reads on consecutive cycles SHALL each return their own data, with o_rdata_vld held high continuously.
REQ-024 When i_mem_wen and i_mem_ren are both high: the write SHALL be performed, the read SHALL return i_mem_wdata (write-first), and o_err SHALL be set with o_err_addr=i_mem_addr.
REQ-025 A read on the cycle after a write to the same word SHALL return the newly written data.
REQ-026 An illegal access SHALL set o_err; o_err_addr SHALL be captured only when o_err was 0 (first fault wins).
REQ-027 i_err_clr=1 SHALL clear o_err at the next edge; if a new fault occurs in that same cycle, the fault wins: o_err stays 1 and o_err_addr takes the new address.
REQ-028 o_rd_cnt and o_wr_cnt SHALL each increment by 1 per legal accepted access and wrap from 32'hFFFF_FFFF to 0.
REQ-029 A simultaneous read and write (REQ-024) SHALL increment both counters when the address is legal.
REQ-030 Array contents SHALL be uninitialised and SHALL NOT be affected by reset.

Reset
REQ-031 While rst_sys=1: o_mem_rdata=0, o_rdata_vld=0, o_err=0, o_err_addr=0, o_rd_cnt=0, o_wr_cnt=0, independent of clk_sys.
REQ-032 A request presented in the cycle that reset asserts SHALL be discarded, and no o_rdata_vld SHALL follow.
REQ-033 The first request accepted at the first rising edge after reset release SHALL be serviced normally.

Verification
REQ-034 Write 32'hDEAD_BEEF to addr 32'h10, then read 32'h10 -> next cycle o_mem_rdata=32'hDEAD_BEEF, o_rdata_vld=1, o_wr_cnt=1, o_rd_cnt=1.
REQ-035 Read addr 32'h2 (misaligned), then read 32'h1000 (out of range, DEPTH=1024) -> rdata=0 with vld on both; o_err=1; o_err_addr=32'h2; counters unchanged.
REQ-036 Assert i_err_clr in the same cycle as a read of 32'h5 -> o_err stays 1, o_err_addr=32'h5; a clear with no fault -> o_err=0.
REQ-037 Write and read together at 32'h20 with wdata 32'h1234_5678 -> rdata=32'h1234_5678, o_err=1, o_err_addr=32'h20; a later read of 32'h20 returns 32'h1234_5678.
REQ-038 Preload o_wr_cnt to 32'hFFFF_FFFF via forced writes, then perform one legal write -> o_wr_cnt=0.
REQ-039 Assert rst_sys mid-cycle during a pending read -> all outputs 0 immediately, no vld pulse; the first read after release returns the pre-reset array contents.

Source files
------------

// File: rtl/dmem_resp.sv
`default_nettype none
// ============================================================================
// Module : dmem_resp
// Brief  : Data memory with 1-cycle registered read response, sticky
//          access-error capture and legal-access counters.
// Rev    : 1.0  initial release
// ============================================================================
module dmem_resp #(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk_sys,
  input  logic        rst_sys,
  input  logic        i_mem_wen,
  input  logic        i_mem_ren,
  input  logic [31:0] i_mem_addr,
  input  logic [31:0] i_mem_wdata,
  output logic [31:0] o_mem_rdata,
  output logic        o_rdata_vld,
  input  logic        i_err_clr,
  output logic        o_err,
  output logic [31:0] o_err_addr,
  output logic [31:0] o_rd_cnt,
  output logic [31:0] o_wr_cnt
);

  localparam int unsigned c_idx_w = $clog2(DEPTH);
  // One bit wider than the address so DEPTH*4 == 2**32 still compares correctly
  localparam logic [32:0] c_span  = 33'(DEPTH) * 33'd4;

  logic [31:0]        r_mem [DEPTH];
  logic [31:0]        r_rdata;
  logic               r_vld;
  logic               r_err;
  logic [31:0]        r_err_addr;
  logic [31:0]        r_rd_cnt;
  logic [31:0]        r_wr_cnt;

  logic [31:0]        w_offset;
  logic [c_idx_w-1:0] w_idx;
  logic               w_legal;
  logic               w_rd_acc;
  logic               w_wr_acc;
  logic               w_fault;
  logic [31:0]        w_rd_word;

  // Unsigned wrap of the subtraction turns "below BASE_ADDR" into "too large"
  assign w_offset = i_mem_addr - BASE_ADDR;
  assign w_idx    = w_offset[c_idx_w+1:2];
  assign w_legal  = (i_mem_addr[1:0] == 2'b00) && ({1'b0, w_offset} < c_span);
  assign w_rd_acc = i_mem_ren & w_legal;
  assign w_wr_acc = i_mem_wen & w_legal;
  // A simultaneous read and write is flagged even when the address is legal
  assign w_fault  = (i_mem_wen | i_mem_ren) & (~w_legal | (i_mem_wen & i_mem_ren));

  always_comb begin
    w_rd_word = 32'h0000_0000;
    if (w_legal) begin
      if (i_mem_wen) begin
        w_rd_word = i_mem_wdata;
      end else begin
        w_rd_word = r_mem[w_idx];
      end
    end
  end

  always_ff @(posedge clk_sys or posedge rst_sys) begin
    if (rst_sys) begin
      // contents are kept; reset only suppresses a write at this edge
    end else if (w_wr_acc) begin
      r_mem[w_idx] <= i_mem_wdata;
    end
  end

  always_ff @(posedge clk_sys or posedge rst_sys) begin
    if (rst_sys) begin
      r_rdata <= 32'h0000_0000;
      r_vld   <= 1'b0;
    end else begin
      r_vld <= i_mem_ren;
      if (i_mem_ren) begin
        r_rdata <= w_rd_word;
      end
    end
  end

  // First fault wins, except that a fault coinciding with a clear restarts capture
  always_ff @(posedge clk_sys or posedge rst_sys) begin
    if (rst_sys) begin
      r_err      <= 1'b0;
      r_err_addr <= 32'h0000_0000;
    end else if (w_fault) begin
      r_err <= 1'b1;
      if (!r_err || i_err_clr) begin
        r_err_addr <= i_mem_addr;
      end
    end else if (i_err_clr) begin
      r_err <= 1'b0;
    end
  end

  always_ff @(posedge clk_sys or posedge rst_sys) begin
    if (rst_sys) begin
      r_rd_cnt <= 32'h0000_0000;
      r_wr_cnt <= 32'h0000_0000;
    end else begin
      if (w_rd_acc) begin
        r_rd_cnt <= r_rd_cnt + 32'd1;
      end
      if (w_wr_acc) begin
        r_wr_cnt <= r_wr_cnt + 32'd1;
      end
    end
  end

  assign o_mem_rdata = r_rdata;
  assign o_rdata_vld = r_vld;
  assign o_err       = r_err;
  assign o_err_addr  = r_err_addr;
  assign o_rd_cnt    = r_rd_cnt;
  assign o_wr_cnt    = r_wr_cnt;

endmodule
`default_nettype wire

// File: tb/tb_dmem_resp.sv
`default_nettype none
// ============================================================================
// Module : tb_dmem_resp
// Brief  : Self-checking bench for dmem_resp: directed vector table, reference
//          model under random traffic, reset and counter-wrap sequences.
// Rev    : 1.0  initial release
// ============================================================================
module tb_dmem_resp;

  localparam int          DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic        clk_sys;
  logic        rst_sys;
  logic        mem_wen;
  logic        mem_ren;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        rdata_vld;
  logic        err_clr;
  logic        err;
  logic [31:0] err_addr;
  logic [31:0] rd_cnt;
  logic [31:0] wr_cnt;

  int n_vec;
  int n_miscmp;

  dmem_resp #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk_sys     (clk_sys),
    .rst_sys     (rst_sys),
    .i_mem_wen   (mem_wen),
    .i_mem_ren   (mem_ren),
    .i_mem_addr  (mem_addr),
    .i_mem_wdata (mem_wdata),
    .o_mem_rdata (mem_rdata),
    .o_rdata_vld (rdata_vld),
    .i_err_clr   (err_clr),
    .o_err       (err),
    .o_err_addr  (err_addr),
    .o_rd_cnt    (rd_cnt),
    .o_wr_cnt    (wr_cnt)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic        wen;
    logic        ren;
    logic        clr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        vld;
    logic [31:0] rdata;
    logic        err;
    logic [31:0] ea;
    logic [31:0] rd;
    logic [31:0] wr;
  } vec_t;

  vec_t tbl[14];

  // Reference model state
  logic [31:0] m_mem [int];
  logic        m_vld;
  logic [31:0] m_rdata;
  logic        m_err;
  logic [31:0] m_ea;
  logic [31:0] m_rd;
  logic [31:0] m_wr;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic vld, input logic [31:0] rdata,
                           input logic e, input logic [31:0] ea,
                           input logic [31:0] rd, input logic [31:0] wr);
    cmp({tag, "_vld"},   {31'b0, rdata_vld}, {31'b0, vld});
    cmp({tag, "_rdata"}, mem_rdata, rdata);
    cmp({tag, "_err"},   {31'b0, err}, {31'b0, e});
    cmp({tag, "_eaddr"}, err_addr, ea);
    cmp({tag, "_rdcnt"}, rd_cnt, rd);
    cmp({tag, "_wrcnt"}, wr_cnt, wr);
  endtask

  function automatic bit is_legal(input logic [31:0] a);
    longint off;
    off = longint'(a) - longint'(BASE);
    return (a % 4 == 0) && (off >= 0) && (off < longint'(DEPTH) * 4);
  endfunction

  task automatic model_reset();
    m_vld   = 1'b0;
    m_rdata = 32'h0;
    m_err   = 1'b0;
    m_ea    = 32'h0;
    m_rd    = 32'h0;
    m_wr    = 32'h0;
  endtask

  task automatic model_edge(input logic wen, input logic ren, input logic clr,
                            input logic [31:0] a, input logic [31:0] wd);
    bit lg;
    int idx;
    bit fault;
    lg  = is_legal(a);
    idx = int'((longint'(a) - longint'(BASE)) / 4);
    m_vld = ren;
    if (ren) m_rdata = !lg ? 32'h0 : (wen ? wd : m_mem[idx]);
    if (wen && lg) m_mem[idx] = wd;
    fault = (wen || ren) && (!lg || (wen && ren));
    if (fault) begin
      if (!m_err || clr) m_ea = a;
      m_err = 1'b1;
    end else if (clr) begin
      m_err = 1'b0;
    end
    if (ren && lg) m_rd = m_rd + 32'd1;
    if (wen && lg) m_wr = m_wr + 32'd1;
  endtask

  task automatic drive(input logic wen, input logic ren, input logic clr,
                       input logic [31:0] a, input logic [31:0] wd);
    mem_wen   = wen;
    mem_ren   = ren;
    err_clr   = clr;
    mem_addr  = a;
    mem_wdata = wd;
  endtask

  // One clock of traffic, checked against the model 1 time unit after the edge
  task automatic step(input string tag, input logic wen, input logic ren, input logic clr,
                      input logic [31:0] a, input logic [31:0] wd);
    drive(wen, ren, clr, a, wd);
    @(posedge clk_sys);
    #1;
    model_edge(wen, ren, clr, a, wd);
    check_all(tag, m_vld, m_rdata, m_err, m_ea, m_rd, m_wr);
  endtask

  initial begin
    n_vec    = 0;
    n_miscmp = 0;
    rst_sys  = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    model_reset();

    //              wen   ren   clr   addr          wdata          vld   rdata         err   ea            rd     wr
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 32'd0, 32'd1};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000, 32'd1, 32'd1};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000, 32'd1, 32'd1};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 32'h0000_0002, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 32'h0000_0002, 32'd1, 32'd1};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 32'h0000_1000, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 32'h0000_0002, 32'd1, 32'd1};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 32'h0000_0005, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 32'h0000_0005, 32'd1, 32'd1};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0005, 32'd1, 32'd1};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 32'h0000_0020, 32'h1234_5678, 1'b1, 32'h1234_5678, 1'b1, 32'h0000_0020, 32'd2, 32'd2};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 32'h0000_0020, 32'h0000_0000, 1'b1, 32'h1234_5678, 1'b1, 32'h0000_0020, 32'd3, 32'd2};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 1'b1, 32'hDEAD_BEEF, 1'b1, 32'h0000_0020, 32'd4, 32'd2};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 32'h0000_0FFC, 32'hA5A5_0001, 1'b0, 32'hDEAD_BEEF, 1'b1, 32'h0000_0020, 32'd4, 32'd3};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 32'h0000_0FFC, 32'h0000_0000, 1'b1, 32'hA5A5_0001, 1'b1, 32'h0000_0020, 32'd5, 32'd3};
    tbl[12] = '{1'b1, 1'b0, 1'b1, 32'h0000_0011, 32'h7777_7777, 1'b0, 32'hA5A5_0001, 1'b1, 32'h0000_0011, 32'd5, 32'd3};
    tbl[13] = '{1'b0, 1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 1'b1, 32'hDEAD_BEEF, 1'b1, 32'h0000_0011, 32'd6, 32'd3};

    repeat (2) @(posedge clk_sys);
    #1;
    check_all("reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0);
    #3 rst_sys = 1'b0;

    // Directed table
    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].wen, tbl[i].ren, tbl[i].clr, tbl[i].addr, tbl[i].wdata);
      @(posedge clk_sys);
      #1;
      check_all($sformatf("tbl%0d", i), tbl[i].vld, tbl[i].rdata, tbl[i].err,
                tbl[i].ea, tbl[i].rd, tbl[i].wr);
    end

    // Re-synchronise DUT and model through a reset, then fill every word
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    #3 rst_sys = 1'b1;
    #1;
    check_all("rst2", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0);
    @(posedge clk_sys);
    #3 rst_sys = 1'b0;
    model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      step("fill", 1'b1, 1'b0, 1'b0, BASE + 32'(i * 4), $urandom);
    end

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      logic        w, r, c;
      logic [31:0] a;
      int          k, idx;
      w   = ($urandom_range(0, 2) == 0);
      r   = ($urandom_range(0, 1) == 0);
      c   = ($urandom_range(0, 15) == 0);
      k   = int'($urandom_range(0, 9));
      idx = int'($urandom_range(0, DEPTH - 1));
      if (k == 0)      a = BASE + 32'(idx * 4) + 32'($urandom_range(1, 3));
      else if (k == 1) a = BASE + 32'(DEPTH * 4) + 32'($urandom_range(0, 255) * 4);
      else             a = BASE + 32'(idx * 4);
      if (w && r) a = BASE + 32'(idx * 4);
      step("rnd", w, r, c, a, $urandom);
    end

    // Reset during a pending read response; a request held across reset is dropped
    step("prerst_w", 1'b1, 1'b0, 1'b0, 32'h0000_0040, 32'hCAFE_0040);
    step("prerst_w2", 1'b1, 1'b0, 1'b0, 32'h0000_0044, 32'hCAFE_0044);
    step("prerst_r", 1'b0, 1'b1, 1'b0, 32'h0000_0040, 32'h0);
    #3 rst_sys = 1'b1;
    #1;
    check_all("rst_async", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 32'h0000_0044, 32'hBAD0_0000);
    @(posedge clk_sys);
    #1;
    check_all("rst_held", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0);
    #3 rst_sys = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk_sys);
    #1;
    check_all("rst_after", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0);
    model_reset();
    step("postrst_r40", 1'b0, 1'b1, 1'b0, 32'h0000_0040, 32'h0);
    cmp("postrst_data40", mem_rdata, 32'hCAFE_0040);
    step("postrst_r44", 1'b0, 1'b1, 1'b0, 32'h0000_0044, 32'h0);
    cmp("postrst_data44", mem_rdata, 32'hCAFE_0044);

    // Write counter wrap from all-ones
    force dut.r_wr_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.r_wr_cnt;
    #1;
    cmp("wrap_preload", wr_cnt, 32'hFFFF_FFFF);
    m_wr = 32'hFFFF_FFFF;
    step("wrap", 1'b1, 1'b0, 1'b0, 32'h0000_0080, 32'h0BAD_F00D);
    cmp("wrap_zero", wr_cnt, 32'h0);

    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
`default_nettype wire
